// File: rtl/pacc_mont_acc_if.sv
// Operand/result bundle for the pointwise-accumulate Montgomery feeder.
// master: operand source / result sink; slave: pacc_mont_acc.
// PACC_PROTO_CHECK_EN adds the proto_err / err_cnt status signals.
interface pacc_mont_acc_if #(
    parameter int unsigned IW = 16,
    parameter int unsigned OW = 16
);
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] iCoeff_a;
    logic signed [IW-1:0] iCoeff_b;
    logic                 busy;
    logic                 PAcc_done;
    logic signed [OW-1:0] oCoeffs;
`ifdef PACC_PROTO_CHECK_EN
    logic                 proto_err;
    logic [7:0]           err_cnt;

    modport master (
        output enable, in_valid, iCoeff_a, iCoeff_b,
        input  in_ready, busy, PAcc_done, oCoeffs, proto_err, err_cnt
    );
    modport slave (
        input  enable, in_valid, iCoeff_a, iCoeff_b,
        output in_ready, busy, PAcc_done, oCoeffs, proto_err, err_cnt
    );
`else
    modport master (
        output enable, in_valid, iCoeff_a, iCoeff_b,
        input  in_ready, busy, PAcc_done, oCoeffs
    );
    modport slave (
        input  enable, in_valid, iCoeff_a, iCoeff_b,
        output in_ready, busy, PAcc_done, oCoeffs
    );
`endif
endinterface

// File: rtl/pacc_mont_acc.sv
// Serial Montgomery multiply-accumulate feeding the Barrett reduction stage.
// Accepts KYBER_K operand pairs per output coefficient, reduces each product
// with Montgomery reduction and sums the results with int16 wrap.
// Optional macro PACC_PROTO_CHECK_EN adds the proto_err / err_cnt monitor.
module pacc_mont_acc #(
    parameter int KYBER_K        = 2,
    parameter int KYBER_Q        = 3329,
    parameter int QINV           = -3327,
    parameter int i_Coeffs_Width = 16,
    parameter int o_Coeffs_Width = 16
) (
    input logic             clk,
    input logic             reset_n,
    pacc_mont_acc_if.slave  bus
);
    localparam int IW = i_Coeffs_Width;
    localparam int OW = o_Coeffs_Width;

    localparam logic [15:0]        Qinv16  = 16'(QINV);
    localparam logic signed [31:0] KqS     = 32'(KYBER_Q);
    localparam logic [1:0]         CntLast = 2'(KYBER_K - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StMul,
        StTmul,
        StRed,
        StAcc
    } state_e;

    state_e               state_q, state_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic [1:0]           cnt_q, cnt_d;
    logic signed [IW-1:0] a_q, a_d;
    logic signed [IW-1:0] b_q, b_d;
    logic signed [31:0]   prod_q, prod_d;
    logic signed [15:0]   t_q, t_d;
    logic signed [OW-1:0] r_q, r_d;
    logic signed [OW-1:0] ocoeffs_q, ocoeffs_d;
    logic                 done_q, done_d;

    logic signed [OW-1:0] sum;
    logic signed [31:0]   red_full;
    logic                 busy;

    assign busy          = (state_q != StIdle);
    assign bus.busy      = busy;
    assign bus.in_ready  = (state_q == StWait);
    assign bus.PAcc_done = done_q;
    assign bus.oCoeffs   = ocoeffs_q;

    // State and datapath registers; reset clears everything, aborting any operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            t_q       <= '0;
            r_q       <= '0;
            ocoeffs_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            prod_q    <= prod_d;
            t_q       <= t_d;
            r_q       <= r_d;
            ocoeffs_q <= ocoeffs_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath: one pipeline step per state, done pulses for one cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        t_d       = t_q;
        r_d       = r_q;
        ocoeffs_d = ocoeffs_q;
        done_d    = 1'b0;
        sum       = acc_q + r_q;
        // Low 16 bits of this difference are zero by construction of t.
        red_full  = prod_q - (32'(t_q) * KqS);

        case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.in_valid) begin
                    a_d     = bus.iCoeff_a;
                    b_d     = bus.iCoeff_b;
                    state_d = StMul;
                end
            end
            StMul: begin
                prod_d  = 32'(a_q) * 32'(b_q);
                state_d = StTmul;
            end
            StTmul: begin
                // 16x16 into a 16-bit result keeps only the low half, as intended.
                t_d     = prod_q[15:0] * Qinv16;
                state_d = StRed;
            end
            StRed: begin
                r_d     = OW'(red_full >>> 16);
                state_d = StAcc;
            end
            StAcc: begin
                if (cnt_q == CntLast) begin
                    ocoeffs_d = sum;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    acc_d   = sum;
                    cnt_d   = cnt_q + 2'd1;
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef PACC_PROTO_CHECK_EN
    logic       proto_err_q;
    logic [7:0] err_cnt_q;

    assign bus.proto_err = proto_err_q;
    assign bus.err_cnt   = err_cnt_q;

    // Sticky flag and saturating count of enable pulses seen while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else if (bus.enable && busy) begin
            proto_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end
`endif
endmodule
